// File: rtl/mmio_pkg.sv
// Shared types and widths for the MMIO slot initiator and its slot mux.
package mmio_pkg;

  localparam int MMIO_DATA_W = 32;
  localparam int MMIO_ADDR_W = 8;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_SLVERR  = 2'b01,
    ERR_DECERR  = 2'b10,
    ERR_TIMEOUT = 2'b11
  } rsp_err_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT     = 2'b01,
    ST_COMPLETE = 2'b10,
    ST_RESP     = 2'b11
  } init_state_e;

endpackage

// File: rtl/mmio_slot_mux.sv
// One-hot chip-select decode and per-slot status selection for the latched target slot.
module mmio_slot_mux
  import mmio_pkg::*;
#(
  parameter int NUM_SLOTS = 8
) (
  input  logic [$clog2(NUM_SLOTS)-1:0]       slot,
  input  logic [MMIO_DATA_W*NUM_SLOTS-1:0]   rd_data,
  input  logic [NUM_SLOTS-1:0]               wr_done,
  input  logic [NUM_SLOTS-1:0]               rd_done,
  input  logic [NUM_SLOTS-1:0]               slave_error,
  input  logic [NUM_SLOTS-1:0]               decode_error,
  output logic [NUM_SLOTS-1:0]               cs,
  output logic [MMIO_DATA_W-1:0]             sel_rdata,
  output logic                               sel_done,
  output logic                               sel_slverr,
  output logic                               sel_decerr
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);

  // Decode and select; an index with no matching slot yields all zeros.
  always_comb begin
    cs         = '0;
    sel_rdata  = '0;
    sel_done   = 1'b0;
    sel_slverr = 1'b0;
    sel_decerr = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (SLOT_W'(i) == slot) begin
        cs[i]      = 1'b1;
        sel_rdata  = rd_data[MMIO_DATA_W*i +: MMIO_DATA_W];
        sel_done   = wr_done[i] | rd_done[i];
        sel_slverr = slave_error[i];
        sel_decerr = decode_error[i];
      end else begin
        cs[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mmio_slot_initiator.sv
// Initiator end of the MMIO slot interface: one outstanding request, driven onto the
// selected slot with a wait-cycle timeout, answered with read data and error status.
module mmio_slot_initiator
  import mmio_pkg::*;
#(
  parameter int NUM_SLOTS      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [$clog2(NUM_SLOTS)-1:0]     req_slot,
  input  logic [MMIO_ADDR_W-1:0]           req_addr,
  input  logic [MMIO_DATA_W-1:0]           req_wdata,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [MMIO_DATA_W-1:0]           rsp_rdata,
  output logic [1:0]                       rsp_err,
  output logic [NUM_SLOTS-1:0]             slot_cs,
  output logic                             slot_read,
  output logic                             slot_write,
  output logic                             slot_txn_done,
  output logic [MMIO_ADDR_W-1:0]           slot_addr,
  output logic [MMIO_DATA_W-1:0]           slot_wdata,
  input  logic [MMIO_DATA_W*NUM_SLOTS-1:0] slot_rd_data,
  input  logic [NUM_SLOTS-1:0]             slot_wr_done,
  input  logic [NUM_SLOTS-1:0]             slot_rd_done,
  input  logic [NUM_SLOTS-1:0]             slot_slave_error,
  input  logic [NUM_SLOTS-1:0]             slot_decode_error
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

  init_state_e              state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     write_q, write_d;
  logic [SLOT_W-1:0]        slot_q, slot_d;
  logic [MMIO_ADDR_W-1:0]   addr_q, addr_d;
  logic [MMIO_DATA_W-1:0]   wdata_q, wdata_d;
  logic [MMIO_DATA_W-1:0]   rdata_q, rdata_d;
  rsp_err_e                 err_q, err_d;
  logic                     rdy_q, rdy_d;

  logic [NUM_SLOTS-1:0]     mux_cs;
  logic [MMIO_DATA_W-1:0]   sel_rdata;
  logic                     sel_done;
  logic                     sel_slverr;
  logic                     sel_decerr;
  logic                     handshake;
  logic                     done_qual;

  mmio_slot_mux #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_mux (
    .slot         (slot_q),
    .rd_data      (slot_rd_data),
    .wr_done      (slot_wr_done),
    .rd_done      (slot_rd_done),
    .slave_error  (slot_slave_error),
    .decode_error (slot_decode_error),
    .cs           (mux_cs),
    .sel_rdata    (sel_rdata),
    .sel_done     (sel_done),
    .sel_slverr   (sel_slverr),
    .sel_decerr   (sel_decerr)
  );

  // Done is ignored for the first two WAIT cycles so a slave still holding DONE is not taken.
  assign done_qual = sel_done && (cnt_q >= CNT_W'(2));
  assign handshake = req_valid && req_ready;

  // Next-state and request/response register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    slot_d  = slot_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    rdy_d   = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          write_d = req_write;
          slot_d  = req_slot;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          cnt_d   = '0;
          if ({1'b0, req_slot} >= (SLOT_W+1)'(NUM_SLOTS)) begin
            err_d   = ERR_DECERR;
            state_d = ST_RESP;
          end else begin
            err_d   = ERR_OK;
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (done_qual) begin
          state_d = ST_COMPLETE;
          if (sel_decerr) begin
            err_d   = ERR_DECERR;
            rdata_d = '0;
          end else if (sel_slverr) begin
            err_d   = ERR_SLVERR;
            rdata_d = '0;
          end else begin
            err_d   = ERR_OK;
            rdata_d = write_q ? '0 : sel_rdata;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_COMPLETE;
          err_d   = ERR_TIMEOUT;
          rdata_d = '0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_COMPLETE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      slot_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      slot_q  <= slot_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  // Outputs come only from state and latched registers, never from inputs.
  assign req_ready     = rdy_q && (state_q == ST_IDLE);
  assign slot_cs       = (state_q == ST_WAIT) ? mux_cs : '0;
  assign slot_read     = (state_q == ST_WAIT) && !write_q;
  assign slot_write    = (state_q == ST_WAIT) && write_q;
  assign slot_txn_done = (state_q == ST_COMPLETE);
  assign slot_addr     = addr_q;
  assign slot_wdata    = wdata_q;
  assign rsp_valid     = (state_q == ST_RESP);
  assign rsp_rdata     = rdata_q;
  assign rsp_err       = err_q;

endmodule

// File: tb/tb_mmio_slot_initiator.sv
// Directed bench: gpio-like 2-stage slave on slot 0, bench-driven slave on slot 1, others silent.
module tb_mmio_slot_initiator;

  localparam int NS = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [2:0]    req_slot;
  logic [7:0]    req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_err;
  logic [NS-1:0] slot_cs;
  logic          slot_read, slot_write, slot_txn_done;
  logic [7:0]    slot_addr;
  logic [31:0]   slot_wdata;
  logic [32*NS-1:0] slot_rd_data;
  logic [NS-1:0] slot_wr_done, slot_rd_done, slot_slave_error, slot_decode_error;

  int passed = 0;
  int total  = 0;

  // gpio model state and slot-1 controls
  logic [1:0]  gp_cnt;
  logic        gp_done, gp_rd;
  logic [31:0] gp_rdata;
  logic        gp_dec, gp_slv;
  logic        s1_rd_done;
  logic [31:0] s1_rdata;

  // per-transaction observations
  int          r_wait, r_rsp_cyc, r_done_cyc, r_done_cnt, r_cs_first, r_cs_last;
  logic [NS-1:0] r_cs_or;
  logic [31:0] r_rd;
  logic [1:0]  r_er;
  logic        r_rd_s1, r_wr_s1;

  always #5 clk = ~clk;

  mmio_slot_initiator #(.NUM_SLOTS(NS), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_slot(req_slot), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .slot_cs(slot_cs), .slot_read(slot_read), .slot_write(slot_write),
    .slot_txn_done(slot_txn_done), .slot_addr(slot_addr), .slot_wdata(slot_wdata),
    .slot_rd_data(slot_rd_data), .slot_wr_done(slot_wr_done), .slot_rd_done(slot_rd_done),
    .slot_slave_error(slot_slave_error), .slot_decode_error(slot_decode_error)
  );

  // 2-stage slave: done rises two cycles after cs, held until txn_done
  always @(posedge clk) begin
    if (rst || slot_txn_done) begin
      gp_cnt  <= 2'd0;
      gp_done <= 1'b0;
      gp_rd   <= 1'b0;
    end else if (slot_cs[0]) begin
      gp_rd <= slot_read;
      if (gp_cnt != 2'd3) gp_cnt <= gp_cnt + 2'd1;
      if (gp_cnt == 2'd1) gp_done <= 1'b1;
    end
  end

  assign gp_rdata = (slot_addr == 8'h04) ? 32'hDEADBEEF : 32'h1234_5678;
  assign gp_dec   = gp_done && ((slot_addr == 8'h10) || (slot_addr == 8'h30));
  assign gp_slv   = gp_done && ((slot_addr == 8'h20) || (slot_addr == 8'h30));

  assign slot_rd_data      = {128'h0, s1_rdata, gp_rdata};
  assign slot_rd_done      = {4'b0, s1_rd_done, gp_done & gp_rd};
  assign slot_wr_done      = {5'b0, gp_done & ~gp_rd};
  assign slot_slave_error  = {5'b0, gp_slv};
  assign slot_decode_error = {5'b0, gp_dec};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it to RESP (left unacknowledged); cycle 1 is the one after handshake.
  task automatic do_txn(input logic wr, input logic [2:0] slot, input logic [7:0] addr,
                        input logic [31:0] wd);
    r_wait = 0;
    while (!req_ready && r_wait < 50) begin
      tick;
      r_wait++;
    end
    req_valid = 1'b1; req_write = wr; req_slot = slot; req_addr = addr; req_wdata = wd;
    tick;
    req_valid = 1'b0;
    r_rsp_cyc = -1; r_done_cyc = -1; r_done_cnt = 0; r_cs_first = -1; r_cs_last = -1;
    r_cs_or = '0; r_rd = 32'hx; r_er = 2'bx; r_rd_s1 = slot_read; r_wr_s1 = slot_write;
    for (int c = 1; c <= 400; c++) begin
      if (slot_cs != '0) begin
        if (r_cs_first < 0) r_cs_first = c;
        r_cs_last = c;
      end
      r_cs_or = r_cs_or | slot_cs;
      if (slot_txn_done) begin
        r_done_cnt++;
        if (r_done_cyc < 0) r_done_cyc = c;
      end
      if (rsp_valid) begin
        r_rsp_cyc = c; r_rd = rsp_rdata; r_er = rsp_err;
        break;
      end
      tick;
    end
  endtask

  task automatic ack_rsp;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    total++; if ({req_ready, rsp_valid, slot_read, slot_write, slot_txn_done} !== 5'b0) $display("FAIL reset_ctrl: got %b expected 00000", {req_ready, rsp_valid, slot_read, slot_write, slot_txn_done}); else passed++;
    total++; if ({slot_cs, rsp_err, rsp_rdata} !== '0) $display("FAIL reset_data: got cs=%b err=%b rdata=%h expected all 0", slot_cs, rsp_err, rsp_rdata); else passed++;
    rst = 1'b0;
    tick;
    total++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_ready); else passed++;
  endtask

  task automatic test_write;
    do_txn(1'b1, 3'd0, 8'h00, 32'h5);
    total++; if (r_rsp_cyc !== 5) $display("FAIL wr_latency: got %0d expected 5", r_rsp_cyc); else passed++;
    total++; if ({r_er, r_rd} !== {2'b00, 32'h0}) $display("FAIL wr_rsp: got err=%b rdata=%h expected 00/0", r_er, r_rd); else passed++;
    total++; if (r_done_cyc !== 4 || r_done_cnt !== 1) $display("FAIL wr_txn_done: got cyc=%0d cnt=%0d expected 4/1", r_done_cyc, r_done_cnt); else passed++;
    total++; if (r_cs_first !== 1 || r_cs_last !== 3 || r_cs_or !== 6'b000001) $display("FAIL wr_cs: got %0d..%0d or=%b expected 1..3 000001", r_cs_first, r_cs_last, r_cs_or); else passed++;
    total++; if ({r_wr_s1, r_rd_s1} !== 2'b10) $display("FAIL wr_strobes: got wr/rd=%b expected 10", {r_wr_s1, r_rd_s1}); else passed++;
    total++; if (slot_wdata !== 32'h5 || slot_addr !== 8'h00) $display("FAIL wr_bus: got wdata=%h addr=%h expected 5/00", slot_wdata, slot_addr); else passed++;
    ack_rsp;
  endtask

  task automatic test_read;
    do_txn(1'b0, 3'd0, 8'h04, 32'h0);
    total++; if (r_rsp_cyc !== 5) $display("FAIL rd_latency: got %0d expected 5", r_rsp_cyc); else passed++;
    total++; if ({r_er, r_rd} !== {2'b00, 32'hDEADBEEF}) $display("FAIL rd_rsp: got err=%b rdata=%h expected 00/deadbeef", r_er, r_rd); else passed++;
    total++; if ({r_wr_s1, r_rd_s1} !== 2'b01) $display("FAIL rd_strobes: got wr/rd=%b expected 01", {r_wr_s1, r_rd_s1}); else passed++;
    ack_rsp;
  endtask

  task automatic test_slave_errors;
    do_txn(1'b1, 3'd0, 8'h10, 32'hA5);
    total++; if ({r_er, r_rd} !== {2'b10, 32'h0}) $display("FAIL decerr_wr: got err=%b rdata=%h expected 10/0", r_er, r_rd); else passed++;
    ack_rsp;
    do_txn(1'b0, 3'd0, 8'h20, 32'h0);
    total++; if ({r_er, r_rd} !== {2'b01, 32'h0}) $display("FAIL slverr_rd: got err=%b rdata=%h expected 01/0", r_er, r_rd); else passed++;
    ack_rsp;
    do_txn(1'b0, 3'd0, 8'h30, 32'h0);
    total++; if ({r_er, r_rd} !== {2'b10, 32'h0}) $display("FAIL both_err: got err=%b rdata=%h expected 10/0", r_er, r_rd); else passed++;
    ack_rsp;
  endtask

  task automatic test_out_of_range;
    do_txn(1'b0, 3'd6, 8'h00, 32'h0);
    total++; if (r_rsp_cyc !== 1 || r_er !== 2'b10 || r_rd !== 32'h0) $display("FAIL oor_rsp: got cyc=%0d err=%b rdata=%h expected 1/10/0", r_rsp_cyc, r_er, r_rd); else passed++;
    total++; if (r_cs_first !== -1 || r_done_cnt !== 0) $display("FAIL oor_quiet: got cs_first=%0d txn_done=%0d expected -1/0", r_cs_first, r_done_cnt); else passed++;
    ack_rsp;
  endtask

  task automatic test_timeout;
    do_txn(1'b0, 3'd3, 8'h08, 32'h0);
    total++; if (r_cs_first !== 1 || r_cs_last !== 255 || r_cs_or !== 6'b001000) $display("FAIL to_cs: got %0d..%0d or=%b expected 1..255 001000", r_cs_first, r_cs_last, r_cs_or); else passed++;
    total++; if (r_done_cyc !== 256 || r_done_cnt !== 1) $display("FAIL to_txn_done: got cyc=%0d cnt=%0d expected 256/1", r_done_cyc, r_done_cnt); else passed++;
    total++; if (r_rsp_cyc !== 257 || r_er !== 2'b11 || r_rd !== 32'h0) $display("FAIL to_rsp: got cyc=%0d err=%b rdata=%h expected 257/11/0", r_rsp_cyc, r_er, r_rd); else passed++;
    ack_rsp;
  endtask

  task automatic test_stale_done;
    s1_rdata = 32'hCAFE0001;
    s1_rd_done = 1'b1;
    do_txn(1'b0, 3'd1, 8'h00, 32'h0);
    total++; if (r_done_cyc !== 4 || r_rsp_cyc !== 5) $display("FAIL stale_mask: got txn_done=%0d rsp=%0d expected 4/5", r_done_cyc, r_rsp_cyc); else passed++;
    total++; if ({r_er, r_rd} !== {2'b00, 32'hCAFE0001}) $display("FAIL stale_rsp: got err=%b rdata=%h expected 00/cafe0001", r_er, r_rd); else passed++;
    ack_rsp;
    s1_rd_done = 1'b0;
  endtask

  task automatic test_back_to_back;
    int stable;
    do_txn(1'b0, 3'd0, 8'h04, 32'h0);
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (rsp_valid === 1'b1 && rsp_rdata === 32'hDEADBEEF && rsp_err === 2'b00 && req_ready === 1'b0) stable++;
    end
    total++; if (stable !== 10) $display("FAIL hold_stable: got %0d stable cycles expected 10", stable); else passed++;
    ack_rsp;
    do_txn(1'b1, 3'd0, 8'h00, 32'h77);
    total++; if (r_wait !== 0 || r_cs_first !== 1 || r_rsp_cyc !== 5) $display("FAIL b2b_1: got wait=%0d cs=%0d rsp=%0d expected 0/1/5", r_wait, r_cs_first, r_rsp_cyc); else passed++;
    ack_rsp;
    do_txn(1'b0, 3'd0, 8'h04, 32'h0);
    total++; if (r_wait !== 0 || r_rsp_cyc !== 5 || r_rd !== 32'hDEADBEEF) $display("FAIL b2b_2: got wait=%0d rsp=%0d rdata=%h expected 0/5/deadbeef", r_wait, r_rsp_cyc, r_rd); else passed++;
    ack_rsp;
    do_txn(1'b0, 3'd0, 8'h08, 32'h0);
    total++; if (r_rsp_cyc !== 5 || r_rd !== 32'h1234_5678 || r_done_cnt !== 1) $display("FAIL b2b_3: got rsp=%0d rdata=%h done=%0d expected 5/12345678/1", r_rsp_cyc, r_rd, r_done_cnt); else passed++;
    ack_rsp;
  endtask

  task automatic test_reset_mid;
    req_valid = 1'b1; req_write = 1'b1; req_slot = 3'd3; req_addr = 8'h44; req_wdata = 32'h99;
    tick;
    req_valid = 1'b0;
    tick;
    total++; if (slot_cs !== 6'b001000) $display("FAIL mid_wait_cs: got %b expected 001000", slot_cs); else passed++;
    rst = 1'b1;
    tick;
    total++; if ({req_ready, rsp_valid, slot_read, slot_write, slot_txn_done, slot_cs} !== '0) $display("FAIL mid_rst_ctrl: got %b expected all 0", {req_ready, rsp_valid, slot_read, slot_write, slot_txn_done, slot_cs}); else passed++;
    total++; if ({slot_addr, slot_wdata, rsp_rdata, rsp_err} !== '0) $display("FAIL mid_rst_data: got addr=%h wdata=%h rdata=%h err=%b expected 0", slot_addr, slot_wdata, rsp_rdata, rsp_err); else passed++;
    rst = 1'b0;
    do_txn(1'b0, 3'd0, 8'h04, 32'h0);
    total++; if (r_rsp_cyc !== 5 || r_er !== 2'b00 || r_rd !== 32'hDEADBEEF) $display("FAIL post_rst_txn: got rsp=%0d err=%b rdata=%h expected 5/00/deadbeef", r_rsp_cyc, r_er, r_rd); else passed++;
    ack_rsp;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_slot = 3'd0; req_addr = 8'h00;
    req_wdata = 32'h0; rsp_ready = 1'b0; s1_rd_done = 1'b0; s1_rdata = 32'h0;
    test_reset;
    test_write;
    test_read;
    test_slave_errors;
    test_out_of_range;
    test_timeout;
    test_stale_done;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
